// File: rtl/array_mult_pipe.sv
// array_mult_pipe
// Pipelined carry-save array multiplier producing the full 2N-bit product of
// two N-bit operands. Each reduction row adds one AND partial-product row to
// the running sum/carry vectors and retires one low product bit. Pipeline
// registers sit after every R rows; a final N-bit ripple adder forms the upper
// half of the product.
//
// Build option: define ARRAY_SIGNED_EN to let tc select Baugh-Wooley signed
// multiplication per operand pair. Without it tc is ignored (unsigned only).
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operand pair valid
//   in_ready   operands accepted this cycle when high (global advance)
//   tc         1 = two's-complement operands (ARRAY_SIGNED_EN only)
//   X, Y       multiplicand, multiplier (N bits)
//   out_valid  product valid
//   out_ready  consumer takes the product this cycle
//   Z          2N-bit product
module array_mult_pipe #(
   parameter int N = 8,
   parameter int R = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           tc,
   input  logic [N-1:0]   X,
   input  logic [N-1:0]   Y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*N-1:0] Z
);

   localparam int S = (N + R - 1) / R;

   // sv/cv hold the running sum/carry at weights j..j+N-1 before row j;
   // lo collects the retired low product bits.
   typedef struct packed {
      logic [N-1:0] x;
      logic [N-1:0] y;
      logic         tc;
      logic [N-1:0] sv;
      logic [N-1:0] cv;
      logic [N-1:0] lo;
   } stage_t;

   // Apply the reduction rows belonging to pipeline stage stg.
   function automatic stage_t reduce(input stage_t d, input int stg);
      stage_t       r;
      logic [N-1:0] pp;
      logic [N-1:0] t;
      logic [N-1:0] co;
      int           first;
      int           last;
      r     = d;
      first = stg * R;
      last  = (stg + 1) * R;
      if (last > N) last = N;
      for (int j = 0; j < N; j++) begin
         if (j >= first && j < last) begin
            pp = r.x & {N{r.y[j]}};
`ifdef ARRAY_SIGNED_EN
            if (r.tc) begin
               if (j < N - 1) pp[N-1] = ~pp[N-1];
               else           pp[N-2:0] = ~pp[N-2:0];
            end
`endif
            t  = r.sv ^ r.cv ^ pp;
            co = (r.sv & r.cv) | (r.sv & pp) | (r.cv & pp);
            r.lo[j] = t[0];
            r.sv    = {1'b0, t[N-1:1]};
`ifdef ARRAY_SIGNED_EN
            // The vacated top sum bit after row 0 sits at weight N, after
            // the last row at weight 2N-1: exactly where the Baugh-Wooley
            // constants go, so they cost no extra adder.
            if (r.tc && (j == 0 || j == N - 1)) r.sv[N-1] = 1'b1;
`endif
            r.cv = co;
         end
      end
      return r;
   endfunction

   function automatic logic [N-1:0] cpa(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] s;
      logic         c;
      c = 1'b0;
      for (int i = 0; i < N; i++) begin
         s[i] = a[i] ^ b[i] ^ c;
         c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      return s;
   endfunction

   stage_t         in_st;
   stage_t         nxt  [S];
   stage_t         bank [S];
   logic   [S-1:0] vld;
   logic           adv;

   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;

`ifndef ARRAY_SIGNED_EN
   logic unused_tc;
   assign unused_tc = tc;
`endif

   always_comb begin
      in_st.x  = X;
      in_st.y  = Y;
`ifdef ARRAY_SIGNED_EN
      in_st.tc = tc;
`else
      in_st.tc = 1'b0;
`endif
      in_st.sv = '0;
      in_st.cv = '0;
      in_st.lo = '0;
   end

   always_comb begin
      nxt[0] = reduce(in_st, 0);
      for (int s = 1; s < S; s++) nxt[s] = reduce(bank[s-1], s);
   end

   // Data registers carry no reset; only valid bits and Z are cleared.
   always_ff @(posedge clk) begin
      if (adv) begin
         for (int s = 0; s < S; s++) bank[s] <= nxt[s];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld       <= '0;
         out_valid <= 1'b0;
         Z         <= '0;
      end else if (adv) begin
         vld[0] <= in_valid;
         for (int s = 1; s < S; s++) vld[s] <= vld[s-1];
         out_valid <= vld[S-1];
         if (vld[S-1]) Z <= {cpa(bank[S-1].sv, bank[S-1].cv), bank[S-1].lo};
      end
   end

endmodule

// File: tb/tb_array_mult_pipe.sv
module tb_array_mult_pipe;

   localparam int S_MAIN = 4;
   localparam int S4     = 2;
   localparam int S16    = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, tc, out_valid, out_ready;
   logic [7:0]  x, y;
   logic [15:0] z;

   logic        in_valid4, in_ready4, tc4, out_valid4, out_ready4;
   logic [3:0]  x4, y4;
   logic [7:0]  z4;

   logic        in_valid16, in_ready16, tc16, out_valid16, out_ready16;
   logic [15:0] x16, y16;
   logic [31:0] z16;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   array_mult_pipe #(.N(8), .R(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .tc(tc),
      .X(x), .Y(y), .out_valid(out_valid), .out_ready(out_ready), .Z(z));

   array_mult_pipe #(.N(4), .R(3)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4), .tc(tc4),
      .X(x4), .Y(y4), .out_valid(out_valid4), .out_ready(out_ready4), .Z(z4));

   array_mult_pipe #(.N(16), .R(1)) dut16 (
      .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16), .tc(tc16),
      .X(x16), .Y(y16), .out_valid(out_valid16), .out_ready(out_ready16), .Z(z16));

   // Reference product: integer multiply of the operands' numeric values,
   // reduced modulo 2^(2n).
   function automatic logic [63:0] ref_mul(input int n, input logic [31:0] a,
                                           input logic [31:0] b, input bit t);
      longint sa, sb, one;
      bit     use_tc;
      logic [63:0] p, mask;
      use_tc = t;
`ifndef ARRAY_SIGNED_EN
      use_tc = 1'b0;
`endif
      one = 1;
      sa  = longint'(a);
      sb  = longint'(b);
      if (use_tc) begin
         if (a[n-1]) sa = sa - (one << n);
         if (b[n-1]) sb = sb - (one << n);
      end
      p    = 64'(sa * sb);
      mask = (64'd1 << (2 * n)) - 64'd1;
      return p & mask;
   endfunction

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; x = 8'h12; y = 8'h34; tc = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (z !== 16'h0) begin errors++; $display("FAIL reset_z: got %h expected 0000", z); end
      checks++; if (out_valid4 !== 1'b0 || out_valid16 !== 1'b0) begin errors++; $display("FAIL reset_sweep_valid: got %b/%b expected 0/0", out_valid4, out_valid16); end
      reset = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_after_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_directed();
      logic [7:0]  vx [4];
      logic [7:0]  vy [4];
      bit          vt [4];
      logic [63:0] e;
      int          k;
      vx = '{8'hFF, 8'h80, 8'hFF, 8'h7F};
      vy = '{8'hFF, 8'h80, 8'h01, 8'h80};
      vt = '{1'b0, 1'b1, 1'b1, 1'b1};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         x = vx[i]; y = vy[i]; tc = vt[i]; in_valid = 1'b1;
         e = ref_mul(8, 32'(vx[i]), 32'(vy[i]), vt[i]);
         #1;
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, in_ready); end
         @(posedge clk); #1;
         in_valid = 1'b0;
         k = 0;
         while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
         checks++; if (k != S_MAIN) begin errors++; $display("FAIL directed_latency[%0d]: got %0d edges expected %0d", i, k, S_MAIN); end
         checks++; if (z !== e[15:0]) begin errors++; $display("FAIL directed_z[%0d]: got %h expected %h", i, z, e[15:0]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] q [$];
      logic [63:0] e;
      int first_c = -1, last_c = -1, got = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 32; c++) begin
         if (c < 20) begin
            x = 8'($urandom); y = 8'($urandom); tc = 1'($urandom); in_valid = 1'b1;
            q.push_back(ref_mul(8, 32'(x), 32'(y), tc));
         end else in_valid = 1'b0;
         @(posedge clk); #1;
         if (out_valid === 1'b1) begin
            if (first_c < 0) first_c = c;
            last_c = c; got++;
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL b2b_extra: got product %h expected none", z); end
            else begin
               e = q.pop_front();
               if (z !== e[15:0]) begin errors++; $display("FAIL b2b_z: got %h expected %h", z, e[15:0]); end
            end
         end
      end
      in_valid = 1'b0;
      checks++; if (got != 20) begin errors++; $display("FAIL b2b_count: got %0d expected 20", got); end
      checks++; if (first_c != S_MAIN || last_c != S_MAIN + 19) begin errors++; $display("FAIL b2b_window: got %0d..%0d expected %0d..%0d", first_c, last_c, S_MAIN, S_MAIN + 19); end
   endtask

   task automatic test_backpressure();
      logic [63:0] q [$];
      logic [63:0] e;
      logic [15:0] zprev;
      bit          stalled, accepted;
      int          acc = 0, got = 0;
      x = 8'($urandom); y = 8'($urandom); tc = 1'($urandom);
      for (int c = 0; c < 70; c++) begin
         out_ready = !(c >= 10 && c <= 12) && !(c >= 20 && c < 28 && $urandom_range(0, 1) == 0);
         in_valid  = (acc < 30);
         #1;
         stalled = (out_valid === 1'b1) && !out_ready;
         checks++; if (in_ready !== !stalled) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", c, in_ready, !stalled); end
         if (out_valid === 1'b1 && out_ready) begin
            checks++; got++;
            if (q.size() == 0) begin errors++; $display("FAIL bp_extra: got product %h expected none", z); end
            else begin
               e = q.pop_front();
               if (z !== e[15:0]) begin errors++; $display("FAIL bp_z: got %h expected %h", z, e[15:0]); end
            end
         end
         zprev    = z;
         accepted = in_valid && (in_ready === 1'b1);
         if (accepted) begin q.push_back(ref_mul(8, 32'(x), 32'(y), tc)); acc++; end
         @(posedge clk); #1;
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || z !== zprev) begin errors++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", c, out_valid, z, zprev); end
         end
         if (accepted) begin x = 8'($urandom); y = 8'($urandom); tc = 1'($urandom); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 30 || q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d retired, %0d left expected 30, 0", got, q.size()); end
   endtask

   task automatic test_reset_midstream();
      int seen = 0, k;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         x = 8'($urandom_range(1, 255)); y = 8'($urandom_range(1, 255)); tc = 1'b0; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
      checks++; if (z !== 16'h0) begin errors++; $display("FAIL mid_reset_z: got %h expected 0000", z); end
      reset = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL mid_reset_stale: got %0d products expected 0", seen); end
      x = 8'd3; y = 8'd5; tc = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; k = 0;
      while (out_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
      checks++; if (k != S_MAIN || z !== 16'h000F) begin errors++; $display("FAIL mid_reset_new: got %h after %0d edges expected 000f after %0d", z, k, S_MAIN); end
      @(posedge clk); #1;
   endtask

   task automatic test_sweep();
      logic [63:0] q4 [$];
      logic [63:0] q16 [$];
      int          c4 [$];
      int          c16 [$];
      logic [63:0] e;
      int          pc, got4 = 0, got16 = 0;
      out_ready4 = 1'b1; out_ready16 = 1'b1;
      for (int c = 0; c < 290; c++) begin
         if (c < 256) begin
            x4 = c[7:4]; y4 = c[3:0]; tc4 = 1'($urandom); in_valid4 = 1'b1;
            q4.push_back(ref_mul(4, 32'(x4), 32'(y4), tc4)); c4.push_back(c);
         end else in_valid4 = 1'b0;
         if (c < 60) begin
            x16 = 16'($urandom); y16 = 16'($urandom); tc16 = 1'($urandom); in_valid16 = 1'b1;
            if (c == 0) begin x16 = 16'hFFFF; y16 = 16'hFFFF; tc16 = 1'b0; end
            if (c == 1) begin x16 = 16'h8000; y16 = 16'h8000; tc16 = 1'b1; end
            q16.push_back(ref_mul(16, 32'(x16), 32'(y16), tc16)); c16.push_back(c);
         end else in_valid16 = 1'b0;
         @(posedge clk); #1;
         if (out_valid4 === 1'b1) begin
            checks++; got4++;
            if (q4.size() == 0) begin errors++; $display("FAIL sweep4_extra: got %h expected none", z4); end
            else begin
               e = q4.pop_front(); pc = c4.pop_front();
               if (z4 !== e[7:0] || c - pc != S4) begin errors++; $display("FAIL sweep4: got %h lat %0d expected %h lat %0d", z4, c - pc, e[7:0], S4); end
            end
         end
         if (out_valid16 === 1'b1) begin
            checks++; got16++;
            if (q16.size() == 0) begin errors++; $display("FAIL sweep16_extra: got %h expected none", z16); end
            else begin
               e = q16.pop_front(); pc = c16.pop_front();
               if (z16 !== e[31:0] || c - pc != S16) begin errors++; $display("FAIL sweep16: got %h lat %0d expected %h lat %0d", z16, c - pc, e[31:0], S16); end
            end
         end
      end
      checks++; if (got4 != 256 || got16 != 60) begin errors++; $display("FAIL sweep_count: got %0d/%0d expected 256/60", got4, got16); end
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; tc = 1'b0; x = '0; y = '0; out_ready = 1'b1;
      in_valid4 = 1'b0; tc4 = 1'b0; x4 = '0; y4 = '0; out_ready4 = 1'b1;
      in_valid16 = 1'b0; tc16 = 1'b0; x16 = '0; y16 = '0; out_ready16 = 1'b1;
      test_reset();
      test_directed();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      test_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
